// File: rtl/intc_arbiter.sv
// Interrupt controller: synchronizes and latches sources, masks, picks the highest index,
// and hands one ID at a time to the control path. Define INTC_NEST_EN for one-level preemption.
module intc_arbiter #(
  parameter int NUM_SRC     = 6,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [31:0]        wd,
  output logic [31:0]        rd,
  output logic               irq_req,
  output logic [2:0]         irq_id,
  input  logic               irq_ack,
  input  logic               eoi
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  state_t             state;
  logic [NUM_SRC-1:0] sync1, sync2, prev, pend, mask, edge_sel;
  logic [NUM_SRC-1:0] rise, eligible, pend_clr, ack_clr;
  logic [7:0]         elig8;
  logic [CW-1:0]      cnt;
  logic               timeout_flag, win_valid, ack_take;
  logic [2:0]         win_id;
  logic               unused_wd;

`ifdef INTC_NEST_EN
  logic               nested;
  logic [2:0]         saved_id;
`else
  logic               nested;
  logic [2:0]         saved_id;
  assign nested   = 1'b0;
  assign saved_id = 3'd0;
`endif

  assign unused_wd = ^wd[31:6];
  assign rise      = sync2 & ~prev;
  assign eligible  = pend & mask;
  assign ack_take  = (state == REQ) && irq_ack;
  assign ack_clr   = ack_take ? (NUM_SRC'(1) << irq_id) : '0;
  assign pend_clr  = ((we && addr == 2'd1) ? wd[NUM_SRC-1:0] : '0) | ack_clr;

  // Highest set index of the eligible vector wins.
  always_comb begin
    elig8              = '0;
    elig8[NUM_SRC-1:0] = eligible;
    win_id             = '0;
    win_valid          = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i]) begin
        win_id    = 3'(i);
        win_valid = 1'b1;
      end
    end
  end

  // Edge sources: a new rising edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      pend  <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      prev  <= sync2;
      for (int i = 0; i < NUM_SRC; i++)
        pend[i] <= edge_sel[i] ? (rise[i] | (pend[i] & ~pend_clr[i])) : sync2[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask     <= '0;
      edge_sel <= '0;
    end else if (we) begin
      if (addr == 2'd0) mask <= wd[NUM_SRC-1:0];
      if (addr == 2'd3) edge_sel <= wd[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      irq_req      <= 1'b0;
      irq_id       <= 3'd0;
      cnt          <= '0;
      timeout_flag <= 1'b0;
`ifdef INTC_NEST_EN
      nested       <= 1'b0;
      saved_id     <= 3'd0;
`endif
    end else begin
      if (we && addr == 2'd2 && wd[5]) timeout_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            state   <= REQ;
            irq_req <= 1'b1;
            irq_id  <= win_id;
            cnt     <= '0;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state   <= SERVICE;
            irq_req <= 1'b0;
          end else if (!elig8[irq_id]) begin
            state   <= IDLE;
            irq_req <= 1'b0;
          end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
            state        <= IDLE;
            irq_req      <= 1'b0;
            timeout_flag <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SERVICE: begin
`ifdef INTC_NEST_EN
          // A nested handler's eret resumes the preempted one instead of idling.
          if (eoi && nested) begin
            irq_id <= saved_id;
            nested <= 1'b0;
          end else if (eoi) begin
            state <= IDLE;
          end else if (!nested && win_valid && (win_id > irq_id)) begin
            saved_id <= irq_id;
            nested   <= 1'b1;
            irq_id   <= win_id;
            state    <= REQ;
            irq_req  <= 1'b1;
            cnt      <= '0;
          end
`else
          if (eoi) state <= IDLE;
`endif
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      2'd0:    rd[NUM_SRC-1:0] = mask;
      2'd1:    rd[NUM_SRC-1:0] = pend;
      2'd2:    rd[9:0]         = {saved_id, nested, timeout_flag, state, irq_id};
      default: rd[NUM_SRC-1:0] = edge_sel;
    endcase
  end

endmodule

// File: tb/tb_intc_arbiter.sv
// Self-checking bench for intc_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level reference model built from the controller's rules.
module tb_intc_arbiter;

  localparam int N  = 6;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst, we, irq_ack, eoi, irq_req;
  logic [N-1:0] irq_in;
  logic [1:0]   addr;
  logic [31:0]  wd, rd;
  logic [2:0]   irq_id;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  intc_arbiter #(.NUM_SRC(N), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack), .eoi(eoi)
  );

  // Reference model: hist[k] is the irq_in value sampled k+1 edges ago.
  logic [N-1:0] hist [0:2];
  logic [N-1:0] m_pend, m_mask, m_edge;
  int           m_state, m_id, m_cnt, m_saved;
  bit           m_req, m_to, m_nested;

  function automatic int highest(input logic [N-1:0] v);
    int h = -1;
    for (int i = 0; i < N; i++) if (v[i]) h = i;
    return h;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0: return 32'(m_mask);
      2'd1: return 32'(m_pend);
      2'd2: return 32'(m_id) | (32'(m_state) << 3) | (32'(m_to) << 5)
                 | (32'(m_nested) << 6) | (32'(m_saved) << 7);
      default: return 32'(m_edge);
    endcase
  endfunction

  task automatic model_step();
    logic [N-1:0] synced, older, elig, clr, n_pend;
    int win;
    if (!rst) begin
      for (int k = 0; k < 3; k++) hist[k] = '0;
      m_pend = '0; m_mask = '0; m_edge = '0;
      m_state = 0; m_id = 0; m_cnt = 0; m_saved = 0;
      m_req = 0; m_to = 0; m_nested = 0;
      return;
    end
    synced = hist[1];
    older  = hist[2];
    elig   = m_pend & m_mask;
    win    = highest(elig);
    clr    = '0;
    if (we && addr == 2'd1) clr = wd[N-1:0];
    if (m_state == 1 && irq_ack) clr[m_id] = 1'b1;
    for (int i = 0; i < N; i++)
      n_pend[i] = m_edge[i] ? ((synced[i] & ~older[i]) | (m_pend[i] & ~clr[i])) : synced[i];
    if (we && addr == 2'd2 && wd[5]) m_to = 0;
    case (m_state)
      0: if (win >= 0) begin m_state = 1; m_req = 1; m_id = win; m_cnt = 0; end
      1: begin
        if (irq_ack) begin m_state = 2; m_req = 0; end
        else if (!elig[m_id]) begin m_state = 0; m_req = 0; end
        else if (m_cnt == TO - 1) begin m_state = 0; m_req = 0; m_to = 1; end
        else m_cnt++;
      end
      default: begin
`ifdef INTC_NEST_EN
        if (eoi && m_nested) begin m_id = m_saved; m_nested = 0; end
        else if (eoi) m_state = 0;
        else if (!m_nested && win > m_id) begin
          m_saved = m_id; m_nested = 1; m_id = win; m_state = 1; m_req = 1; m_cnt = 0;
        end
`else
        if (eoi) m_state = 0;
`endif
      end
    endcase
    if (we && addr == 2'd0) m_mask = wd[N-1:0];
    if (we && addr == 2'd3) m_edge = wd[N-1:0];
    m_pend  = n_pend;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = irq_in;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; irq_in = '0; we = 1'b0; addr = 2'd0; wd = '0; irq_ack = 1'b0; eoi = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    tick();
    we = 1'b0; wd = '0;
  endtask

  task automatic wait_req(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (irq_req === 1'b1) seen = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (irq_req !== 1'b0 || irq_id !== 3'd0) begin
      fails++;
      $display("[TB] FAIL rst_out: irq_req=%b irq_id=%0d, want 0/0", irq_req, irq_id);
    end
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      checks++;
      if (rd !== 32'h0) begin
        fails++;
        $display("[TB] FAIL rst_reg%0d: rd=%h, want 0", a, rd);
      end
    end
  endtask

  task automatic test_level_basic();
    do_reset();
    reg_write(2'd0, 32'h3F);
    irq_in = 6'h04; addr = 2'd1;
    tick(); tick();
    checks++;
    if (rd !== 32'h0) begin fails++; $display("[TB] FAIL lvl_pend_early: rd=%h, want 0", rd); end
    tick();
    checks++;
    if (rd !== 32'h04 || irq_req !== 1'b0) begin
      fails++; $display("[TB] FAIL lvl_pend: rd=%h irq_req=%b, want 04/0", rd, irq_req);
    end
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 3'd2) begin
      fails++; $display("[TB] FAIL lvl_req: irq_req=%b id=%0d, want 1/2", irq_req, irq_id);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    addr = 2'd2; #1;
    checks++;
    if (rd[4:3] !== 2'd2 || irq_req !== 1'b0 || irq_id !== 3'd2) begin
      fails++; $display("[TB] FAIL lvl_service: state=%0d req=%b id=%0d, want 2/0/2", rd[4:3], irq_req, irq_id);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++;
    if (rd[4:3] !== 2'd0 || irq_req !== 1'b0) begin
      fails++; $display("[TB] FAIL lvl_eoi: state=%0d req=%b, want 0/0", rd[4:3], irq_req);
    end
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 3'd2 || rd[4:3] !== 2'd1) begin
      fails++; $display("[TB] FAIL lvl_rereq: req=%b id=%0d state=%0d, want 1/2/1", irq_req, irq_id, rd[4:3]);
    end
    irq_in = '0;
  endtask

  task automatic test_edge_pair();
    do_reset();
    reg_write(2'd3, 32'h3F);
    reg_write(2'd0, 32'h3F);
    irq_in = 6'h22; tick(); irq_in = '0;
    tick();
    addr = 2'd1;
    tick();
    checks++;
    if (rd !== 32'h22 || irq_req !== 1'b0) begin
      fails++; $display("[TB] FAIL edge_pend: rd=%h req=%b, want 22/0", rd, irq_req);
    end
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 3'd5) begin
      fails++; $display("[TB] FAIL edge_first: req=%b id=%0d, want 1/5", irq_req, irq_id);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++;
    if (rd !== 32'h02 || irq_req !== 1'b0) begin
      fails++; $display("[TB] FAIL edge_ackclr: pend=%h req=%b, want 02/0", rd, irq_req);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 3'd1) begin
      fails++; $display("[TB] FAIL edge_second: req=%b id=%0d, want 1/1", irq_req, irq_id);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int n;
    do_reset();
    reg_write(2'd0, 32'h20);
    irq_in = 6'h20;
    wait_req(8, seen);
    checks++;
    if (!seen || irq_id !== 3'd5) begin
      fails++; $display("[TB] FAIL to_wait: seen=%0b id=%0d, want 1/5", seen, irq_id);
    end
    n = 0;
    while (irq_req === 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != TO) begin fails++; $display("[TB] FAIL to_len: high for %0d cycles, want %0d", n, TO); end
    addr = 2'd2; #1;
    checks++;
    if (rd[5] !== 1'b1 || rd[4:3] !== 2'd0) begin
      fails++; $display("[TB] FAIL to_flag: flag=%b state=%0d, want 1/0", rd[5], rd[4:3]);
    end
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 3'd5) begin
      fails++; $display("[TB] FAIL to_rearb: req=%b id=%0d, want 1/5", irq_req, irq_id);
    end
    reg_write(2'd2, 32'h20);
    addr = 2'd2; #1;
    checks++;
    if (rd[5] !== 1'b0) begin fails++; $display("[TB] FAIL to_w1c: flag=%b, want 0", rd[5]); end
    irq_in = '0;
  endtask

  task automatic test_level_drop();
    bit seen;
    int n;
    do_reset();
    reg_write(2'd0, 32'h3F);
    irq_in = 6'h08;
    wait_req(8, seen);
    checks++;
    if (!seen || irq_id !== 3'd3) begin
      fails++; $display("[TB] FAIL drop_req: seen=%0b id=%0d, want 1/3", seen, irq_id);
    end
    irq_in = '0;
    tick();
    n = 0;
    while (irq_req === 1'b1 && n < 3) begin tick(); n++; end
    addr = 2'd2; #1;
    checks++;
    if (irq_req !== 1'b0 || rd[4:3] !== 2'd0) begin
      fails++; $display("[TB] FAIL drop_withdraw: req=%b state=%0d, want 0/0", irq_req, rd[4:3]);
    end
    irq_in = 6'h08;
    tick(); tick(); tick();
    reg_write(2'd1, 32'h08);
    addr = 2'd1; #1;
    checks++;
    if (rd !== 32'h08) begin fails++; $display("[TB] FAIL drop_levelw1c: pend=%h, want 08", rd); end
    irq_in = '0;
  endtask

  task automatic test_nest();
    bit seen;
    do_reset();
    reg_write(2'd3, 32'h3F);
    reg_write(2'd0, 32'h3F);
    irq_in = 6'h02; tick(); irq_in = '0;
    wait_req(8, seen);
    checks++;
    if (!seen || irq_id !== 3'd1) begin
      fails++; $display("[TB] FAIL nest_first: seen=%0b id=%0d, want 1/1", seen, irq_id);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_in = 6'h10; tick(); irq_in = '0;
    wait_req(8, seen);
`ifdef INTC_NEST_EN
    addr = 2'd2; #1;
    checks++;
    if (!seen || irq_id !== 3'd4 || rd[6] !== 1'b1 || rd[9:7] !== 3'd1) begin
      fails++; $display("[TB] FAIL nest_preempt: seen=%0b id=%0d nested=%b saved=%0d, want 1/4/1/1",
                        seen, irq_id, rd[6], rd[9:7]);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++;
    if (rd[4:3] !== 2'd2 || irq_id !== 3'd1 || rd[6] !== 1'b0) begin
      fails++; $display("[TB] FAIL nest_resume: state=%0d id=%0d nested=%b, want 2/1/0", rd[4:3], irq_id, rd[6]);
    end
`else
    checks++;
    if (seen) begin fails++; $display("[TB] FAIL nest_none: irq_req=1 during service, want 0"); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    wait_req(4, seen);
    checks++;
    if (!seen || irq_id !== 3'd4) begin
      fails++; $display("[TB] FAIL nest_after_eoi: seen=%0b id=%0d, want 1/4", seen, irq_id);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    reg_write(2'd0, 32'h3F);
    irq_in = 6'h10;
    wait_req(8, seen);
    checks++;
    if (!seen) begin fails++; $display("[TB] FAIL midrst_req: seen=0, want 1"); end
    rst = 1'b0;
    tick();
    addr = 2'd0; #1;
    checks++;
    if (irq_req !== 1'b0 || rd !== 32'h0) begin
      fails++; $display("[TB] FAIL midrst_mask: req=%b mask=%h, want 0/0", irq_req, rd);
    end
    addr = 2'd1; #1;
    checks++;
    if (rd !== 32'h0) begin fails++; $display("[TB] FAIL midrst_pend: pend=%h, want 0", rd); end
    addr = 2'd2; #1;
    checks++;
    if (rd !== 32'h0) begin fails++; $display("[TB] FAIL midrst_status: status=%h, want 0", rd); end
    rst = 1'b1; irq_in = '0;
  endtask

  task automatic test_random();
    do_reset();
    reg_write(2'd0, 32'h3F);
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 7) == 0) irq_in = N'($urandom);
      irq_ack = ($urandom_range(0, 5) == 0);
      eoi     = ($urandom_range(0, 6) == 0);
      we      = ($urandom_range(0, 5) == 0);
      addr    = 2'($urandom);
      wd      = $urandom;
      tick();
      checks++;
      if (irq_req !== m_req || irq_id !== 3'(m_id)) begin
        fails++; $display("[TB] FAIL rnd_out c=%0d: req=%b id=%0d, want %b/%0d", c, irq_req, irq_id, m_req, m_id);
      end
      checks++;
      if (rd !== model_rd(addr)) begin
        fails++; $display("[TB] FAIL rnd_rd c=%0d addr=%0d: rd=%h, want %h", c, addr, rd, model_rd(addr));
      end
    end
    rst = 1'b1; we = 1'b0; irq_ack = 1'b0; eoi = 1'b0; irq_in = '0;
  endtask

  initial begin
    test_reset();
    test_level_basic();
    test_edge_pair();
    test_timeout();
    test_level_drop();
    test_nest();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/intc_arbiter.md
Name: intc_arbiter

Overview:
Interrupt controller that sits between the raw interrupt sources (external pins plus the timer flag) and the CP0 exception entry. It synchronizes the sources, detects edges, and latches pending requests. It applies a software mask, arbitrates by fixed priority, and presents one interrupt ID at a time to the control path using a req/ack/eoi handshake. Memory-mapped control registers give software access to mask, pending, edge-select and status.

Parameters:
NUM_SRC, 6, number of interrupt sources (2..8); bit NUM_SRC-1 has the highest priority.
ACK_TIMEOUT, 16, cycles irq_req may stay high without irq_ack before the request is withdrawn.

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-low
irq_in  in  NUM_SRC  raw interrupt sources, asynchronous to clk
we  in  1  register write enable
addr  in  2  register select: 0 MASK, 1 PEND, 2 STATUS, 3 EDGE
wd  in  32  register write data
rd  out  32  register read data, combinational from addr
irq_req  out  1  interrupt request to the control path
irq_id  out  3  ID of the requested interrupt; valid while irq_req=1
irq_ack  in  1  one-cycle pulse: exception taken (EXL set)
eoi  in  1  one-cycle pulse: handler returned (eret)

Behaviour:
- Reset (rst=0 at a clk edge): MASK=0, EDGE=0, PEND=0, sync flops=0, state=IDLE, irq_req=0, irq_id=0, timeout flag=0, nested=0, saved_id=0.
- Input path: each source goes through a 2-flop synchronizer, then a rising-edge detector that compares the synced value against its previous value.
- Level sources (EDGE[i]=0): PEND[i] tracks the synced level.
- Edge sources (EDGE[i]=1): a synced rising edge sets PEND[i]. The bit clears on a write to addr 1 with wd[i]=1 (write-1-to-clear) or on irq_ack for ID i. If set and clear happen in the same cycle, set wins.
- Writes to PEND bits of level sources are ignored.
- Latency: irq_in is first sampled high at edge N; PEND shows it after edge N+2; irq_req goes high after edge N+3 if the controller was IDLE and the bit is masked in.
- eligible = PEND & MASK[NUM_SRC-1:0]. The winner is the highest set index.
- Register writes take effect on the next edge. MASK and EDGE use wd[NUM_SRC-1:0]. Unused rd bits read 0.
- STATUS fields: [2:0] irq_id, [4:3] state (IDLE=0, REQ=1, SERVICE=2), [5] timeout sticky (write-1-to-clear), [6] nested, [9:7] saved_id.
- FSM, IDLE:
  - irq_req=0.
  - If eligible!=0: latch the winner into irq_id, clear the timeout counter, go to REQ.
  - irq_ack and eoi are ignored.
- FSM, REQ:
  - irq_req=1 and irq_id is held stable. No re-arbitration happens, even if a higher-priority source arrives.
  - On irq_ack: go to SERVICE and clear PEND[irq_id] if it is an edge source.
  - Else if eligible[irq_id]=0 (level dropped or mask cleared): withdraw and go to IDLE. irq_req is low for at least one cycle.
  - Else if the counter reaches ACK_TIMEOUT-1: set the timeout flag and go to IDLE. irq_req is low for at least one cycle before re-arbitration.
  - irq_ack takes precedence over a withdrawal or timeout in the same cycle.
- FSM, SERVICE:
  - irq_req=0 and irq_id keeps the in-service ID.
  - On eoi: go to IDLE. The next request can assert on the following edge.
  - irq_ack is ignored.
- Reset mid-operation: every state and register returns to its reset value immediately, including in-flight pending bits.

Optional Feature:
- Macro: INTC_NEST_EN.
- When defined: in SERVICE, an eligible source with an index above irq_id preempts the handler.
  - saved_id takes the current ID, nested=1, and the FSM goes to REQ with the new ID.
  - After ack, eoi with nested=1 returns to SERVICE with irq_id=saved_id and clears nested.
  - Nesting depth is 1: while nested=1, no further preemption occurs.
- When undefined: SERVICE is never preempted. nested and saved_id read 0.

Test Plan:
- Reset with MASK=0x3F, EDGE=0, irq_in=0x04 held from cycle 0 -> irq_req=1 and irq_id=2 after edge 3; pulse irq_ack -> STATUS[4:3]=2; pulse eoi -> back to REQ with id 2 on the next edge (level still high).
- EDGE=0x3F, MASK=0x3F, one-cycle pulses on sources 1 and 5 in the same cycle -> PEND=0x22; irq_id=5 first. After ack, PEND=0x02. After eoi, irq_id=1.
- MASK=0x20, request id 5, never ack -> irq_req drops after 16 cycles and STATUS[5]=1; write addr2 wd=0x20 -> STATUS[5]=0.
- Level source 3 in REQ, then irq_in[3] drops before ack -> irq_req=0 within 3 cycles and state=IDLE; PEND write 0x08 to a level source has no effect.
- INTC_NEST_EN defined: servicing id 1, edge on source 4 -> irq_req with id 4 and STATUS[6]=1, saved_id=1; ack then eoi -> SERVICE with id 1 and nested=0. Undefined: no irq_req until eoi.
- Assert rst=0 while in REQ -> next edge irq_req=0, MASK=0, PEND=0, state=IDLE.
